// File: rtl/pipe_ctrl_pkg.sv
// pipe_pkg: shared pc_sel codes, FSM states and Beta opcode/instruction constants.
package pipe_pkg;
  typedef enum logic [2:0] {
    PC_4     = 3'd0,
    PC_OFF   = 3'd1,
    PC_JMP   = 3'd2,
    PC_ILLOP = 3'd3,
    PC_XADR  = 3'd4,
    PC_RESET = 3'd5
  } pcsel_t;
  typedef enum logic [1:0] {BOOT, RUN, IRQ_WAIT} ctrl_state_t;
  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;
  localparam logic [31:0] NOP    = 32'h83fff800;
  localparam logic [31:0] BNE_XP = 32'h77df0000;
  function automatic logic is_xfer(input logic [5:0] op);
    return op == OP_JMP || op == OP_BEQ || op == OP_BNE;
  endfunction
  function automatic logic is_mem(input logic [5:0] op);
    return op == OP_LD || op == OP_ST || op == OP_LDR;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: RF-stage hazard/control inputs and pipeline control outputs of the sequencer.
interface pipe_ctrl_if;
  import pipe_pkg::*;
  logic stall, bt, jt, RF_exp, mem_busy, irq, sup;
  pcsel_t pc_sel;
  logic if_en, rf_en, alu_en, mem_en, wb_en, annul_IF, irq_inject, irq_ack;
  modport master (
    output stall, bt, jt, RF_exp, mem_busy, irq, sup,
    input  pc_sel, if_en, rf_en, alu_en, mem_en, wb_en, annul_IF, irq_inject, irq_ack
  );
  modport slave (
    input  stall, bt, jt, RF_exp, mem_busy, irq, sup,
    output pc_sel, if_en, rf_en, alu_en, mem_en, wb_en, annul_IF, irq_inject, irq_ack
  );
endinterface

// File: rtl/pipe_ctrl_sync_ff.sv
// sync_ff: N-deep level synchronizer with synchronous active-high reset.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [N-1:0] r_q;
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else begin
      r_q[0] <= i_d;
      for (int k = 1; k < N; k++) r_q[k] <= r_q[k-1];
    end
  end
  assign o_q = r_q[N-1];
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Beta 5-stage pipeline sequencer; PIPE_CTRL_PERF_EN adds performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int IRQ_SYNC = 2,
  parameter int CNT_W    = 32
) (
  input logic clk,
  input logic rst,
  pipe_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] irq_cnt
`endif
);
  ctrl_state_t r_state, w_next;
  logic w_irq_s, w_take;
  sync_ff #(.N(IRQ_SYNC)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.irq),
    .o_q (w_irq_s)
  );
  // a branch/jump in RF defers the interrupt so XP captures the right resume PC
  assign w_take = r_state == RUN && w_irq_s && !bus.sup && !bus.bt && !bus.jt;
  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next         = r_state;
    bus.pc_sel     = PC_4;
    bus.if_en      = 1'b1;
    bus.rf_en      = 1'b1;
    bus.alu_en     = 1'b1;
    bus.mem_en     = 1'b1;
    bus.wb_en      = 1'b1;
    bus.annul_IF   = 1'b0;
    bus.irq_inject = 1'b0;
    bus.irq_ack    = 1'b0;
    if (r_state == BOOT) begin
      bus.pc_sel   = PC_RESET;
      bus.annul_IF = 1'b1;
      w_next       = RUN;
    end else if (bus.mem_busy) begin
      {bus.if_en, bus.rf_en, bus.alu_en, bus.mem_en, bus.wb_en} = 5'b0;
    end else begin
      if (r_state == IRQ_WAIT && bus.sup) w_next = RUN;
      if (bus.stall) bus.if_en = 1'b0;
      else if (bus.RF_exp) begin
        bus.pc_sel   = PC_ILLOP;
        bus.annul_IF = 1'b1;
      end else if (w_take) begin
        bus.pc_sel     = PC_XADR;
        bus.annul_IF   = 1'b1;
        bus.irq_inject = 1'b1;
        bus.irq_ack    = 1'b1;
        w_next         = IRQ_WAIT;
      end else if (bus.bt || bus.jt) begin
        bus.pc_sel   = bus.bt ? PC_OFF : PC_JMP;
        bus.annul_IF = 1'b1;
      end
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      irq_cnt   <= '0;
    end else if (r_state != BOOT) begin
      cyc_cnt   <= cyc_cnt + 1'b1;
      stall_cnt <= stall_cnt + CNT_W'(bus.mem_busy || bus.stall);
      flush_cnt <= flush_cnt + CNT_W'(bus.annul_IF);
      irq_cnt   <= irq_cnt + CNT_W'(bus.irq_ack);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; counter checks compile in with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_ctrl_if bus();
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0] cyc_cnt, stall_cnt, flush_cnt, irq_cnt;
`endif
  pipe_ctrl #(.IRQ_SYNC(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_CTRL_PERF_EN
    , .cyc_cnt   (cyc_cnt)
    , .stall_cnt (stall_cnt)
    , .flush_cnt (flush_cnt)
    , .irq_cnt   (irq_cnt)
`endif
  );
  always #5 clk = ~clk;
  // input vector {rst, mem_busy, stall, bt, jt, RF_exp, irq, sup}
  localparam logic [7:0] I_0 = 8'h00, I_RST = 8'h80, I_MB = 8'h40, I_ST = 8'h20, I_BT = 8'h10;
  localparam logic [7:0] I_JT = 8'h08, I_EXP = 8'h04, I_IRQ = 8'h02, I_SUP = 8'h01;
  // output vector {pc_sel, if_en, rf_en, alu_en, mem_en, wb_en, annul_IF, irq_inject, irq_ack}
  localparam logic [10:0] RUN_OK = {3'd0, 5'b11111, 3'b000};
  localparam logic [10:0] FROZEN = {3'd0, 5'b00000, 3'b000};
  localparam logic [10:0] BOOTV  = {3'd5, 5'b11111, 3'b100};
  localparam logic [10:0] STALLV = {3'd0, 5'b01111, 3'b000};
  localparam logic [10:0] ILLV   = {3'd3, 5'b11111, 3'b100};
  localparam logic [10:0] IRQV   = {3'd4, 5'b11111, 3'b111};
  localparam logic [10:0] BTV    = {3'd1, 5'b11111, 3'b100};
  localparam logic [10:0] JTV    = {3'd2, 5'b11111, 3'b100};
  logic [10:0] q_exp[$];
  logic [10:0] q_obs[$];
  logic [10:0] e, o;
  int n_cmp = 0;
  int n_err = 0;
  task automatic step(input logic [7:0] in, input logic [10:0] exp);
    @(posedge clk);
    #1;
    {rst, bus.mem_busy, bus.stall, bus.bt, bus.jt, bus.RF_exp, bus.irq, bus.sup} = in;
    q_exp.push_back(exp);
    @(negedge clk);
    q_obs.push_back({bus.pc_sel, bus.if_en, bus.rf_en, bus.alu_en, bus.mem_en, bus.wb_en,
                     bus.annul_IF, bus.irq_inject, bus.irq_ack});
  endtask
  task automatic test_reset();
    repeat (3) step(I_RST, BOOTV);
    step(I_0, BOOTV);
    step(I_0, RUN_OK);
    step(I_0, RUN_OK);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset #%0d: got %b want %b", n_cmp, o, e); end
    end
  endtask
  task automatic test_load_use();
    step(I_ST | I_BT, STALLV);
    step(I_BT, BTV);
    step(I_0, RUN_OK);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL load_use #%0d: got %b want %b", n_cmp, o, e); end
    end
  endtask
  task automatic test_freeze();
    repeat (2) step(I_IRQ | I_SUP, RUN_OK);
    repeat (4) step(I_MB | I_EXP | I_IRQ, FROZEN);
    step(I_EXP | I_IRQ, ILLV);
    repeat (2) step(I_SUP, RUN_OK);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL freeze #%0d: got %b want %b", n_cmp, o, e); end
    end
  endtask
  task automatic test_irq_jump();
    repeat (2) step(I_IRQ | I_SUP, RUN_OK);
    step(I_IRQ | I_JT, JTV);
    step(I_IRQ, IRQV);
    repeat (2) step(I_IRQ, RUN_OK);
    step(I_IRQ | I_SUP, RUN_OK);
    step(I_IRQ, IRQV);
    repeat (3) step(I_SUP, RUN_OK);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL irq_jump #%0d: got %b want %b", n_cmp, o, e); end
    end
  endtask
  task automatic test_reset_irq_wait();
    repeat (2) step(I_IRQ | I_SUP, RUN_OK);
    step(I_IRQ, IRQV);
    step(I_RST | I_IRQ, RUN_OK);
    step(I_IRQ, BOOTV);
    step(I_IRQ, RUN_OK);
    step(I_IRQ, IRQV);
    repeat (3) step(I_SUP, RUN_OK);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rst_irq_wait #%0d: got %b want %b", n_cmp, o, e); end
    end
  endtask
  task automatic test_perf();
`ifdef PIPE_CTRL_PERF_EN
    step(I_RST, RUN_OK);
    step(I_0, BOOTV);
    repeat (21) step(I_0, RUN_OK);
    n_cmp++;
    if (cyc_cnt !== 4'd4) begin n_err++; $display("FAIL cyc_cnt: got %0d want 4", cyc_cnt); end
    repeat (3) step(I_MB, FROZEN);
    step(I_0, RUN_OK);
    n_cmp++;
    if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
    n_cmp++;
    if ({flush_cnt, irq_cnt} !== 8'h00) begin
      n_err++; $display("FAIL flush_irq_cnt: got %0d/%0d want 0/0", flush_cnt, irq_cnt);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL perf #%0d: got %b want %b", n_cmp, o, e); end
    end
`endif
  endtask
  initial begin
    {bus.mem_busy, bus.stall, bus.bt, bus.jt, bus.RF_exp, bus.irq, bus.sup} = '0;
    test_reset();
    test_load_use();
    test_freeze();
    test_irq_jump();
    test_reset_irq_wait();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage Beta pipeline (IF, RF, ALU, MEM, WB).
- Consumes hazard and control-flow indications from the RF stage (stall, bt, jt, RF_exp), the data-memory busy flag and the external interrupt line.
- Drives per-stage register enables, the PC mux select, the IF-slot annul, and interrupt injection into RF.
- Arbitrates all simultaneous control events with one fixed priority.

Parameters:
- IRQ_SYNC, 2, number of flops in the irq input synchronizer (minimum 1).
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  RF load-use hazard from the RF stage.
- bt  in  1  taken BEQ/BNE in RF.
- jt  in  1  JMP in RF.
- RF_exp  in  1  illegal opcode in RF.
- mem_busy  in  1  data memory not ready; freeze the whole pipe.
- irq  in  1  asynchronous interrupt request, level.
- sup  in  1  pc_RF[31], supervisor bit of the RF instruction.
- pc_sel  out  3  0=PC+4, 1=pc_offset, 2=JMP target, 3=ILLOP vector, 4=XADR (irq) vector, 5=RESET vector.
- if_en  out  1  load the PC and the IF->RF register.
- rf_en  out  1  load the RF->ALU register.
- alu_en, mem_en, wb_en  out  1 each  downstream stage register loads.
- annul_IF  out  1  next id_RF is forced to NOP.
- irq_inject  out  1  RF replaces its instruction with the XP-saving BNE.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.

Behaviour:
- FSM states: BOOT, RUN, IRQ_WAIT.
- On rst: state=BOOT, synchronizer cleared. All outputs are combinational from state and inputs.
- BOOT: lasts 1 cycle with pc_sel=5, if_en=1, annul_IF=1, all other enables=1, irq_inject=0. Then go to RUN.
- RUN and IRQ_WAIT use this per-cycle priority, first match wins:
  1. mem_busy=1: all enables=0, annul_IF=0, pc_sel=0. bt/jt/RF_exp/stall are ignored. State holds.
  2. stall=1: if_en=0; rf_en, alu_en, mem_en, wb_en=1 (RF injects its own NOP). bt/jt/RF_exp are ignored because the bypass values are invalid. pc_sel=0.
  3. RF_exp=1: pc_sel=3, annul_IF=1, all enables=1.
  4. Interrupt take, only when all of the following hold: state=RUN, irq_s=1, sup=0, bt=0, jt=0.
     - Outputs: irq_inject=1, irq_ack=1, pc_sel=4, annul_IF=1, all enables=1.
     - Next state: IRQ_WAIT.
     - A branch in RF defers the interrupt by at least one cycle so that XP captures the correct resume PC.
  5. bt=1: pc_sel=1, annul_IF=1. Otherwise jt=1: pc_sel=2, annul_IF=1.
  6. Otherwise: pc_sel=0, all enables=1, annul_IF=0.
- IRQ_WAIT: no interrupt is accepted. Exit to RUN on the first non-frozen cycle with sup=1, i.e. once a handler instruction reaches RF.
- irq_s is irq after IRQ_SYNC flops. Interrupt latency from an irq edge is at least IRQ_SYNC+1 cycles.
- irq is level-sensitive. A request deasserted before it is taken is lost; no pending latch.
- rst asserted mid-operation (including mid mem_busy or IRQ_WAIT) forces BOOT on the next edge, regardless of other inputs.
- Invariant: irq_inject and annul_IF never assert while if_en=0. At most one of pc_sel codes 1-4 is active per cycle.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds outputs cyc_cnt, stall_cnt, flush_cnt, irq_cnt (each CNT_W bits). All clear on rst.
  - cyc_cnt increments every non-BOOT cycle.
  - stall_cnt increments on priority 1 or 2 cycles.
  - flush_cnt increments on any cycle with annul_IF=1 outside BOOT.
  - irq_cnt increments on irq_ack.
  - All counters wrap at 2^CNT_W to 0.
- When undefined, these ports and their logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the pc_sel codes as an enum typedef pcsel_t;
  - the FSM state enum ctrl_state_t;
  - opcode constants OP_LD=6'h18, OP_ST=6'h19, OP_JMP=6'h1B, OP_BEQ=6'h1C, OP_BNE=6'h1D, OP_LDR=6'h1F;
  - the instruction constants NOP=32'h83fff800 and BNE_XP=32'h77df0000.
- One sub-module, sync_ff (IRQ_SYNC-deep level synchronizer with synchronous reset), used for irq.

Test Plan:
1. Boot: hold rst 3 cycles, release → pc_sel=5, annul_IF=1 for exactly 1 cycle, then pc_sel=0 with all enables=1.
2. Load-use with simultaneous bt: stall=1, bt=1 for 1 cycle → if_en=0, rf_en=1, pc_sel=0. Next cycle stall=0, bt=1 → pc_sel=1, annul_IF=1.
3. Freeze priority: mem_busy=1 for 4 cycles with RF_exp=1 and irq_s=1 → all enables=0 and no irq_ack during those cycles. After release: pc_sel=3 (RF_exp beats irq), irq_ack still 0.
4. Interrupt with a jump present: irq=1 while jt=1 → pc_sel=2 and irq_ack=0 that cycle. Next cycle (jt=0, sup=0) → irq_inject=1, irq_ack=1, pc_sel=4. Then with irq still 1 and sup=0 for 2 cycles → no second ack. After sup=1 for one cycle → back to RUN.
5. Reset mid-IRQ_WAIT: take irq, assert rst while sup=0 → next cycle state BOOT, pc_sel=5. irq_s=0 for IRQ_SYNC cycles after release.
6. With PIPE_CTRL_PERF_EN and CNT_W=4: run 20 cycles with no events → cyc_cnt=4 (wrapped). A 3-cycle mem_busy burst → stall_cnt=3.
